// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } tts_state_t;

    // Largest golden table the helpers accept: 8 outputs x 256 vectors.
    localparam int TBL_MAX = 8 * 256;

    // Entry idx of a packed golden table, zero-extended to 8 bits.
    function automatic logic [7:0] exp_entry(input logic [TBL_MAX-1:0] tbl,
                                             input int                 idx,
                                             input int                 n_out);
        logic [TBL_MAX-1:0] sh;
        sh = tbl >> (idx * n_out);
        return sh[7:0] & 8'((1 << n_out) - 1);
    endfunction

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/tts_hold_counter.sv
// Hold-time counter: counts HOLD cycles per vector and raises a registered terminal strobe.
// Latency: sample is high in the cycle the count equals HOLD-1 (every running cycle when HOLD=1).
// Backpressure: none; clr restarts the count, dropping run idles it at zero.
// Ports: clk, rst_n; clr (restart at 0 next cycle); run (keep counting next cycle);
//        sample (registered terminal-count strobe).
module tts_hold_counter #(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic sample
);
    localparam int            CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sample_q;
    logic          sample_d;

    // The strobe is computed from the next count so it lines up with that
    // count in the same cycle while still coming straight from a flop.
    always_comb begin
        cnt_d    = '0;
        sample_d = 1'b0;
        if (clr || (run && sample_q)) begin
            cnt_d    = '0;
            sample_d = (LAST == '0);
        end else if (run) begin
            cnt_d    = cnt_q + CW'(1);
            sample_d = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep of 2^N_IN input vectors against a golden truth table, counting mismatches.
// Latency: stim=0 one edge after start; done rises 2^N_IN*HOLD cycles after the start edge.
// Backpressure: none; start is ignored unless idle.
// Ports: clk, rst_n, start (launch pulse), stim/vec_idx (current vector), dut_y (DUT response),
//        busy, sample (compare strobe), err_count, first_err, done (level), pass.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int                          N_IN      = 3,
    parameter int                          N_OUT     = 1,
    parameter int                          HOLD      = 10,
    parameter logic [N_OUT*(2**N_IN)-1:0]  EXP_TABLE = 8'b1110_1000,
    parameter bit                          LOOP      = 1'b0,
    parameter int                          ERRW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_y,
    output logic             busy,
    output logic             sample,
    output logic [N_IN-1:0]  vec_idx,
    output logic [ERRW-1:0]  err_count,
    output logic [N_IN-1:0]  first_err,
    output logic             done,
    output logic             pass
);
    localparam logic [N_IN-1:0] LAST_VEC = '1;
    localparam logic [ERRW-1:0] ERR_MAX  = '1;

    tts_state_t      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic            cnt_clr, cnt_run;
    logic            sample_q;
    logic [7:0]      exp8;
    logic            mismatch;

    tts_hold_counter #(
        .HOLD (HOLD)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .run    (cnt_run),
        .sample (sample_q)
    );

    assign exp8 = exp_entry(TBL_MAX'(EXP_TABLE), int'(vec_q), N_OUT);
    // Case-inequality so an unknown response is never mistaken for a match.
    assign mismatch = (8'(dut_y) !== exp8);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        first_d = first_q;
        done_d  = done_q;
        cnt_clr = 1'b0;
        cnt_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    done_d  = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            APPLY: begin
                if (sample_q) begin
                    if (mismatch) begin
                        err_d = ERRW'(sat_inc(32'(err_q), 32'(ERR_MAX)));
                        if (err_q == '0) first_d = vec_q;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_run = 1'b1;
                    end
                end else begin
                    cnt_run = 1'b1;
                end
            end
            DONE: begin
                if (LOOP) begin
                    // Back-to-back sweeps: done stays high for this cycle only.
                    state_d = APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    done_d  = 1'b0;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == APPLY);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            first_q <= first_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = vec_q;
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign sample    = sample_q;
    assign err_count = err_q;
    assign first_err = first_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for the truth-table sweeper: three instances (default majority, 2-input XOR with HOLD=1
// and a 2-bit error counter, looping majority) driven by randomised fault tables.
// Each DUT response is looked up from a table indexed by stim; expectations come from counting.
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit maj(input int i);
        return (((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2);
    endfunction

    function automatic bit xor2(input int i);
        return bit'((i & 1) ^ ((i >> 1) & 1));
    endfunction

    // ---------------- instance A: defaults (majority, HOLD=10) ----------------
    logic       start_a;
    logic [2:0] stim_a, vec_a, first_a;
    logic [7:0] err_a, resp_a;
    logic       dut_y_a, busy_a, sample_a, done_a, pass_a;
    assign dut_y_a = resp_a[stim_a];

    truth_table_sweeper u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .dut_y(dut_y_a),
        .busy(busy_a), .sample(sample_a), .vec_idx(vec_a), .err_count(err_a),
        .first_err(first_a), .done(done_a), .pass(pass_a)
    );

    // ---------------- instance X: XOR, HOLD=1, ERRW=2 ----------------
    logic       start_x;
    logic [1:0] stim_x, vec_x, first_x, err_x;
    logic [3:0] resp_x;
    logic       dut_y_x, busy_x, sample_x, done_x, pass_x;
    assign dut_y_x = resp_x[stim_x];

    truth_table_sweeper #(
        .N_IN(2), .N_OUT(1), .HOLD(1), .EXP_TABLE(4'b0110), .LOOP(1'b0), .ERRW(2)
    ) u_x (
        .clk(clk), .rst_n(rst_n), .start(start_x), .stim(stim_x), .dut_y(dut_y_x),
        .busy(busy_x), .sample(sample_x), .vec_idx(vec_x), .err_count(err_x),
        .first_err(first_x), .done(done_x), .pass(pass_x)
    );

    // ---------------- instance L: looping majority ----------------
    logic       start_l;
    logic [2:0] stim_l, vec_l, first_l;
    logic [7:0] err_l, resp_l;
    logic       dut_y_l, busy_l, sample_l, done_l, pass_l;
    assign dut_y_l = resp_l[stim_l];

    truth_table_sweeper #(
        .N_IN(3), .N_OUT(1), .HOLD(10), .EXP_TABLE(8'b1110_1000), .LOOP(1'b1), .ERRW(8)
    ) u_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .stim(stim_l), .dut_y(dut_y_l),
        .busy(busy_l), .sample(sample_l), .vec_idx(vec_l), .err_count(err_l),
        .first_err(first_l), .done(done_l), .pass(pass_l)
    );

    function automatic logic [7:0] maj_table();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = maj(i);
        return t;
    endfunction

    // One full sweep on A. extra_k: cycle index at which a spurious start is pulsed
    // mid-sweep (-1 = none). start_in_done: also pulse start during the DONE cycle.
    task automatic run_a(input int extra_k, input bit start_in_done);
        int nerr;
        int first;
        nerr  = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if (resp_a[i] != maj(i)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check("a_err_cleared", 32'(err_a), 32'd0);
        for (int k = 0; k < 80; k++) begin
            check("a_sweep", {stim_a, vec_a, busy_a, sample_a, done_a},
                  {3'(k / 10), 3'(k / 10), 1'b1, (k % 10 == 9), 1'b0});
            start_a = (k == extra_k);
            @(negedge clk);
        end
        start_a = 1'b0;
        check("a_done", {busy_a, sample_a, done_a, pass_a}, {1'b0, 1'b0, 1'b1, (nerr == 0)});
        check("a_err_count", 32'(err_a), 32'(nerr));
        check("a_first_err", 32'(first_a), 32'(first));
        start_a = start_in_done;
        @(negedge clk) start_a = 1'b0;
        @(negedge clk);
        check("a_idle_hold", {busy_a, done_a, pass_a, err_a},
              {1'b0, 1'b1, (nerr == 0), 8'(nerr)});
    endtask

    task automatic run_x();
        int nerr;
        int first;
        nerr  = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (resp_x[i] != xor2(i)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        @(negedge clk) start_x = 1'b1;
        @(negedge clk) start_x = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("x_sweep", {stim_x, busy_x, sample_x, done_x}, {2'(k), 1'b1, 1'b1, 1'b0});
            @(negedge clk);
        end
        check("x_done", {busy_x, sample_x, done_x, pass_x}, {1'b0, 1'b0, 1'b1, (nerr == 0)});
        check("x_err_sat", 32'(err_x), (nerr > 3) ? 32'd3 : 32'(nerr));
        check("x_first_err", 32'(first_x), 32'(first));
        @(negedge clk);
    endtask

    task automatic reset_mid_sweep();
        resp_a = 8'h00;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_pre_vec", 32'(stim_a), 32'd4);
        check("rst_pre_err", 32'(err_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_a", {stim_a, busy_a, sample_a, vec_a, err_a, first_a, done_a, pass_a}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_a(-1, 1'b0);
    endtask

    // Looping instance: one start, then a sweep every 2^N*HOLD APPLY cycles plus the DONE cycle.
    task automatic run_l(input int mid_k);
        int nerr;
        int first;
        int p;
        nerr  = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            if (resp_l[i] != maj(i)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        @(negedge clk) start_l = 1'b1;
        @(negedge clk) start_l = 1'b0;
        for (int k = 0; k < 3 * 81; k++) begin
            p = k % 81;
            if (p < 80)
                check("l_sweep", {stim_l, busy_l, done_l, pass_l}, {3'(p / 10), 1'b1, 1'b0, 1'b0});
            else
                check("l_done", {stim_l, busy_l, done_l, pass_l}, {3'd7, 1'b0, 1'b1, (nerr == 0)});
            if (p == 0)  check("l_err_cleared", 32'(err_l), 32'd0);
            if (p == 80) begin
                check("l_err_count", 32'(err_l), 32'(nerr));
                check("l_first_err", 32'(first_l), 32'(first));
            end
            start_l = (k == mid_k);
            @(negedge clk);
        end
        start_l = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_x = 1'b0;
        start_l = 1'b0;
        resp_a  = maj_table();
        resp_x  = 4'b0110;
        resp_l  = maj_table();
        repeat (3) @(negedge clk);
        check("reset_a", {stim_a, busy_a, sample_a, vec_a, err_a, first_a, done_a, pass_a}, 32'd0);
        check("reset_x", {stim_x, busy_x, sample_x, vec_x, err_x, first_x, done_x, pass_x}, 32'd0);
        check("reset_l", {stim_l, busy_l, sample_l, vec_l, err_l, first_l, done_l, pass_l}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Correct majority circuit, then output stuck at 0 (with ignored starts).
        run_a(-1, 1'b0);
        resp_a = 8'h00;
        run_a(25, 1'b1);
        // Randomly corrupted majority circuits.
        for (int r = 0; r < 5; r++) begin
            resp_a = maj_table() ^ 8'($urandom);
            run_a(int'($urandom_range(0, 79)), 1'($urandom_range(0, 1)));
        end

        // XOR: correct, fully inverted (saturates), then random faults.
        resp_x = 4'b0110;
        run_x();
        resp_x = 4'b1001;
        run_x();
        for (int r = 0; r < 4; r++) begin
            resp_x = 4'b0110 ^ 4'($urandom);
            run_x();
        end

        reset_mid_sweep();

        resp_l = maj_table() ^ 8'($urandom);
        run_l(81 + int'($urandom_range(5, 70)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
